rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 43 ++++
 rtl/rom_arbiter.sv | 86 ++++++++
 tb/tb_rom_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM read arbiter: default geometry, requester tags
// and the read-tracking pipeline stage payload.
package rom_arbiter_pkg;

  localparam int unsigned AW_DEF     = 4;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned RD_LAT_DEF = 1;

  typedef enum logic {
    TAG_REQ0 = 1'b0,
    TAG_REQ1 = 1'b1
  } tag_e;

  // One slot of the in-flight read tracker
  typedef struct packed {
    logic vld;
    tag_e tag;
  } pipe_stg_t;

  // Tag of the requester named by a one-hot (or empty) grant vector
  function automatic tag_e tag_of(input logic [1:0] gnt);
    return gnt[1] ? TAG_REQ1 : TAG_REQ0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational within the request cycle,
// the pointer always moves to the requester that was not granted.
module rr_arb2
  import rom_arbiter_pkg::*;
(
  input  logic       sclk,
  input  logic       nrst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  tag_e ptr_q;
  tag_e ptr_d;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      ptr_q <= TAG_REQ0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grant is forced low while reset is asserted
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (nrst && en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_q == TAG_REQ1) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0]) begin
      ptr_d = TAG_REQ1;
    end else if (gnt[1]) begin
      ptr_d = TAG_REQ0;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two read requesters onto one single-port ROM and returns the data
// RD_LAT+2 cycles after each grant, tagged back to the requester that issued it.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic          sclk,
  input  logic          nrst,
  input  logic          en,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          vld0,
  output logic          vld1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q
);

  // One stage for the rom_addr register plus RD_LAT stages of ROM latency
  localparam int unsigned NSTG = RD_LAT + 1;

  logic [1:0]                gnt;
  logic [AW-1:0]             rom_addr_q, rom_addr_d;
  pipe_stg_t [NSTG-1:0]      pipe_q, pipe_d;
  pipe_stg_t                 stg_in, stg_out;
  logic                      vld0_q, vld0_d;
  logic                      vld1_q, vld1_d;
  logic [DW-1:0]             rdata_q, rdata_d;

  rr_arb2 u_rr_arb2 (
    .sclk (sclk),
    .nrst (nrst),
    .req  ({req1, req0}),
    .en   (en),
    .gnt  (gnt)
  );

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      rom_addr_q <= '0;
      pipe_q     <= '0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      pipe_q     <= pipe_d;
      vld0_q     <= vld0_d;
      vld1_q     <= vld1_d;
      rdata_q    <= rdata_d;
    end
  end

  // Stage 0 enters with the grant; the last stage lines up with valid rom_q
  always_comb begin
    stg_in     = '0;
    rom_addr_d = rom_addr_q;
    stg_in.vld = |gnt;
    stg_in.tag = tag_of(gnt);
    if (gnt[1]) begin
      rom_addr_d = addr1;
    end else if (gnt[0]) begin
      rom_addr_d = addr0;
    end
    pipe_d  = {pipe_q[NSTG-2:0], stg_in};
    stg_out = pipe_q[NSTG-1];
    vld0_d  = stg_out.vld && (stg_out.tag == TAG_REQ0);
    vld1_d  = stg_out.vld && (stg_out.tag == TAG_REQ1);
    rdata_d = stg_out.vld ? rom_q : rdata_q;
  end

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign vld0     = vld0_q;
  assign vld1     = vld1_q;
  assign rdata    = rdata_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a 1-cycle ROM model returning 8'hA0|addr.
module tb_rom_arbiter;

  logic       sclk;
  logic       nrst;
  logic       en;
  logic       req0, req1;
  logic [3:0] addr0, addr1;
  logic       gnt0, gnt1, vld0, vld1;
  logic [7:0] rdata;
  logic [3:0] rom_addr;
  logic [7:0] rom_q;

  int n_chk;
  int n_fail;

  rom_arbiter #(.AW(4), .DW(8), .RD_LAT(1)) dut (
    .sclk     (sclk),
    .nrst     (nrst),
    .en       (en),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .vld0     (vld0),
    .vld1     (vld1),
    .rdata    (rdata),
    .rom_addr (rom_addr),
    .rom_q    (rom_q)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // ROM model: samples rom_addr on the edge, data valid one cycle later
  always @(posedge sclk) rom_q <= 8'hA0 | {4'h0, rom_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge sclk);
    #1;
  endtask

  // Grants must be mutually exclusive in every cycle
  always @(negedge sclk) chk("mutex", 32'(gnt0 & gnt1), 32'd0);

  logic [3:0] wrap_addr [3];
  logic [7:0] wrap_data [3];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    wrap_addr = '{4'hE, 4'hF, 4'h0};
    wrap_data = '{8'hAE, 8'hAF, 8'hA0};
    nrst  = 1'b0;
    en    = 1'b1;
    req0  = 1'b1;
    req1  = 1'b0;
    addr0 = 4'h3;
    addr1 = 4'h0;

    // Reset state with a request pending
    @(negedge sclk);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_vld", 32'({vld0, vld1}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);

    // Single request granted on the first edge after reset release
    nxt();
    nrst = 1'b1;
    @(negedge sclk);
    chk("single_gnt0", 32'(gnt0), 32'd1);
    nxt();
    req0 = 1'b0;
    @(negedge sclk);
    chk("single_gnt0_off", 32'(gnt0), 32'd0);
    chk("single_rom_addr", 32'(rom_addr), 32'h3);
    nxt();
    @(negedge sclk);
    chk("single_vld0_early", 32'(vld0), 32'd0);
    nxt();
    @(negedge sclk);
    chk("single_vld0", 32'(vld0), 32'd1);
    chk("single_rdata", 32'(rdata), 32'hA3);
    nxt();
    @(negedge sclk);
    chk("single_vld0_end", 32'(vld0), 32'd0);
    chk("single_rdata_hold", 32'(rdata), 32'hA3);

    // Contention from reset: pointer restarts at requester 0 and alternates
    nxt();
    nrst  = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 4'h1;
    addr1 = 4'h2;
    nxt();
    nxt();
    nrst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge sclk);
      chk("cont_gnt0", 32'(gnt0), 32'((k % 2) == 0));
      chk("cont_gnt1", 32'(gnt1), 32'((k % 2) == 1));
      if (k >= 1)
        chk("cont_rom_addr", 32'(rom_addr), ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
      if (k >= 3) begin
        chk("cont_vld0", 32'(vld0), 32'(((k - 3) % 2) == 0));
        chk("cont_vld1", 32'(vld1), 32'(((k - 3) % 2) == 1));
        chk("cont_rdata", 32'(rdata), (((k - 3) % 2) == 0) ? 32'hA1 : 32'hA2);
      end else begin
        chk("cont_vld_early", 32'({vld0, vld1}), 32'd0);
      end
      nxt();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) nxt();

    // Back-to-back grants for requester 1 across the address wrap
    for (int j = 0; j < 7; j++) begin
      if (j < 3) begin
        req1  = 1'b1;
        addr1 = wrap_addr[j];
      end else begin
        req1 = 1'b0;
      end
      @(negedge sclk);
      chk("b2b_gnt1", 32'(gnt1), 32'(j < 3));
      chk("b2b_vld1", 32'(vld1), 32'((j >= 3) && (j <= 5)));
      chk("b2b_vld0", 32'(vld0), 32'd0);
      if (j >= 1 && j <= 3)
        chk("b2b_rom_addr", 32'(rom_addr), 32'(wrap_addr[j-1]));
      if (j >= 3 && j <= 5)
        chk("b2b_rdata", 32'(rdata), 32'(wrap_data[j-3]));
      if (j == 6)
        chk("b2b_rdata_hold", 32'(rdata), 32'hA0);
      nxt();
    end

    // Enable gating with one read already in flight when en falls
    for (int e = 0; e < 10; e++) begin
      if (e == 0) begin
        en = 1'b1; req0 = 1'b1; addr0 = 4'h5;
      end else if (e <= 5) begin
        en = 1'b0; req0 = 1'b1; addr0 = 4'h7;
      end else if (e == 6) begin
        en = 1'b1;
      end else begin
        req0 = 1'b0;
      end
      @(negedge sclk);
      chk("en_gnt0", 32'(gnt0), 32'((e == 0) || (e == 6)));
      chk("en_vld0", 32'(vld0), 32'((e == 3) || (e == 9)));
      if (e >= 1 && e <= 6)
        chk("en_rom_addr_hold", 32'(rom_addr), 32'h5);
      if (e == 7)
        chk("en_rom_addr", 32'(rom_addr), 32'h7);
      if (e == 3)
        chk("en_rdata_inflight", 32'(rdata), 32'hA5);
      if (e == 9)
        chk("en_rdata", 32'(rdata), 32'hA7);
      nxt();
    end

    // Reset one cycle after a grant to requester 1 discards that read
    req1  = 1'b1;
    addr1 = 4'h9;
    @(negedge sclk);
    chk("rmf_gnt1", 32'(gnt1), 32'd1);
    nxt();
    nrst = 1'b0;
    req1 = 1'b0;
    @(negedge sclk);
    chk("rmf_rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rmf_rst_vld", 32'({vld0, vld1}), 32'd0);
    chk("rmf_rst_rdata", 32'(rdata), 32'd0);
    chk("rmf_rst_rom_addr", 32'(rom_addr), 32'd0);
    nxt();
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge sclk);
    chk("rmf_rst_gnt_gated", 32'({gnt0, gnt1}), 32'd0);
    nxt();
    nrst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    for (int r = 0; r < 5; r++) begin
      @(negedge sclk);
      chk("rmf_no_vld1", 32'(vld1), 32'd0);
      chk("rmf_no_vld0", 32'(vld0), 32'd0);
      nxt();
    end
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 4'h2;
    addr1 = 4'h3;
    @(negedge sclk);
    chk("rmf_ptr_gnt0", 32'(gnt0), 32'd1);
    nxt();
    @(negedge sclk);
    chk("rmf_ptr_gnt1", 32'(gnt1), 32'd1);
    nxt();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
